// File: rtl/char_pkg.sv
// char_pkg: shared types, default constants and helpers for the character
// controller (char_motion_ctrl and its weapon timer).
//   coord_t  : 12-bit screen coordinate
//   wide_t   : 13-bit intermediate used for clamped position/speed math
//   vstate_t : vertical motion state
//   wstate_t : weapon swing state
package char_pkg;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   wide_t;

  typedef enum logic [1:0] {GROUNDED = 2'd0, RISING = 2'd1, FALLING = 2'd2} vstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SWING = 2'd1, W_COOL = 2'd2} wstate_t;

  localparam int DEF_X_MIN         = 0;
  localparam int DEF_X_MAX         = 960;
  localparam int DEF_X_START       = 100;
  localparam int DEF_Y_FLOOR       = 400;
  localparam int DEF_MOVE_STEP     = 4;
  localparam int DEF_JUMP_V0       = 16;
  localparam int DEF_GRAVITY       = 1;
  localparam int DEF_VY_MAX        = 16;
  localparam int DEF_HP_W          = 4;
  localparam int DEF_HP_MAX        = 10;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_WPN_FRAMES    = 15;
  localparam int DEF_WPN_COOL      = 10;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // a - b, floored at zero.
  function automatic wide_t sub_sat0(input wide_t a, input wide_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/char_wpn_timer.sv
// char_wpn_timer: weapon swing FSM with swing and cooldown counters.
//   clk, rst      : clock, asynchronous active-low reset
//   frame_tick    : one-cycle frame strobe; state only moves on it
//   mouse_left    : attack button level, sampled at tick
//   dead          : forces W_IDLE at tick
//   draw_weapon   : registered, high while swinging
module char_wpn_timer
  import char_pkg::*;
#(
  parameter int WPN_FRAMES = DEF_WPN_FRAMES,
  parameter int WPN_COOL   = DEF_WPN_COOL
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic mouse_left,
  input  logic dead,
  output logic draw_weapon
);

  localparam int CNT_TOP = (WPN_FRAMES > WPN_COOL) ? WPN_FRAMES : WPN_COOL;
  localparam int CNT_W   = cnt_bits(CNT_TOP);
  // The tick spent back in W_IDLE is part of the cooldown, so a held button
  // yields exactly WPN_FRAMES ticks on and WPN_COOL ticks off.
  localparam int COOL_LOAD = (WPN_COOL > 0) ? WPN_COOL - 1 : 0;

  wstate_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             draw_weapon_q, draw_weapon_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_dec = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
    if (frame_tick) begin
      if (dead) begin
        state_d = W_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          W_IDLE: begin
            if (mouse_left) begin
              state_d = W_SWING;
              cnt_d   = CNT_W'(WPN_FRAMES);
            end
          end
          W_SWING: begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) begin
              state_d = W_COOL;
              cnt_d   = CNT_W'(COOL_LOAD);
            end
          end
          W_COOL: begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) state_d = W_IDLE;
          end
          default: begin
            state_d = W_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
    draw_weapon_d = (state_d == W_SWING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= W_IDLE;
      cnt_q         <= '0;
      draw_weapon_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      draw_weapon_q <= draw_weapon_d;
    end
  end

  assign draw_weapon = draw_weapon_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: per-frame character controller. Walking with clamps,
// jump/gravity FSM, weapon swing (char_wpn_timer), hit points with an
// invulnerability window and a sticky death flag.
//   clk, rst                 : clock, asynchronous active-low reset
//   frame_tick               : one-cycle pulse per frame; all state moves on it
//   stepleft/right/jump      : movement levels, sampled at tick
//   mouse_left               : attack level, sampled at tick
//   on_ground                : collision level, sampled at tick
//   hit, dmg_amt             : damage pulse (any cycle) and amount
//   pos_x, pos_y             : registered position
//   flip_h                   : 1 = facing left
//   draw_weapon              : swing active
//   char_hp, dead            : hit points, sticky death flag
module char_motion_ctrl
  import char_pkg::*;
#(
  parameter int X_MIN         = DEF_X_MIN,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int X_START       = DEF_X_START,
  parameter int Y_FLOOR       = DEF_Y_FLOOR,
  parameter int MOVE_STEP     = DEF_MOVE_STEP,
  parameter int JUMP_V0       = DEF_JUMP_V0,
  parameter int GRAVITY       = DEF_GRAVITY,
  parameter int VY_MAX        = DEF_VY_MAX,
  parameter int HP_W          = DEF_HP_W,
  parameter int HP_MAX        = DEF_HP_MAX,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int WPN_FRAMES    = DEF_WPN_FRAMES,
  parameter int WPN_COOL      = DEF_WPN_COOL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            stepleft,
  input  logic            stepright,
  input  logic            stepjump,
  input  logic            mouse_left,
  input  logic            on_ground,
  input  logic            hit,
  input  logic [HP_W-1:0] dmg_amt,
  output logic [11:0]     pos_x,
  output logic [11:0]     pos_y,
  output logic            flip_h,
  output logic            draw_weapon,
  output logic [HP_W-1:0] char_hp,
  output logic            dead
);

  localparam int VY_TOP = (JUMP_V0 > VY_MAX) ? JUMP_V0 : VY_MAX;
  localparam int VY_W   = cnt_bits(VY_TOP);
  localparam int INV_W  = cnt_bits(INVULN_FRAMES);

  coord_t            pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic              flip_q, flip_d;
  vstate_t           vst_q, vst_d;
  logic [VY_W-1:0]   vy_q, vy_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              dead_q, dead_d;
  logic [INV_W-1:0]  invuln_q, invuln_d;
  logic              pend_q, pend_d;
  logic [HP_W-1:0]   pend_amt_q, pend_amt_d;

  // 13-bit candidates for every clamped move, computed unconditionally.
  wide_t x_w, y_w, x_left, x_right, rise_vy, y_up, vy_up, vy_fall, y_down;

  always_comb begin
    x_w     = wide_t'(pos_x_q);
    y_w     = wide_t'(pos_y_q);
    x_left  = sub_sat0(x_w, wide_t'(MOVE_STEP));
    if (x_left < wide_t'(X_MIN)) x_left = wide_t'(X_MIN);
    x_right = x_w + wide_t'(MOVE_STEP);
    if (x_right > wide_t'(X_MAX)) x_right = wide_t'(X_MAX);
    // The jump tick already performs the first rising step at JUMP_V0.
    rise_vy = (vst_q == GROUNDED) ? wide_t'(JUMP_V0) : wide_t'(vy_q);
    y_up    = sub_sat0(y_w, rise_vy);
    vy_up   = sub_sat0(rise_vy, wide_t'(GRAVITY));
    vy_fall = wide_t'(vy_q) + wide_t'(GRAVITY);
    if (vy_fall > wide_t'(VY_MAX)) vy_fall = wide_t'(VY_MAX);
    y_down  = y_w + vy_fall;
  end

  // Horizontal movement and facing.
  always_comb begin
    pos_x_d = pos_x_q;
    flip_d  = flip_q;
    if (frame_tick && !dead_q) begin
      if (stepleft && !stepright) begin
        pos_x_d = coord_t'(x_left);
        flip_d  = 1'b1;
      end else if (stepright && !stepleft) begin
        pos_x_d = coord_t'(x_right);
        flip_d  = 1'b0;
      end
    end
  end

  // Vertical FSM.
  logic do_rise;
  always_comb begin
    vst_d   = vst_q;
    vy_d    = vy_q;
    pos_y_d = pos_y_q;
    do_rise = 1'b0;
    if (frame_tick && !dead_q) begin
      case (vst_q)
        GROUNDED: begin
          if (stepjump) begin
            do_rise = 1'b1;
          end else if (!on_ground && (y_w < wide_t'(Y_FLOOR))) begin
            vst_d = FALLING;
            vy_d  = '0;
          end
        end
        RISING: do_rise = 1'b1;
        FALLING: begin
          if (on_ground) begin
            vst_d = GROUNDED;
            vy_d  = '0;
          end else if (y_down >= wide_t'(Y_FLOOR)) begin
            pos_y_d = coord_t'(Y_FLOOR);
            vst_d   = GROUNDED;
            vy_d    = '0;
          end else begin
            pos_y_d = coord_t'(y_down);
            vy_d    = VY_W'(vy_fall);
          end
        end
        default: begin
          vst_d = GROUNDED;
          vy_d  = '0;
        end
      endcase
      if (do_rise) begin
        pos_y_d = coord_t'(y_up);
        if ((vy_up == '0) || (y_up == '0)) begin
          vst_d = FALLING;
          vy_d  = '0;
        end else begin
          vst_d = RISING;
          vy_d  = VY_W'(vy_up);
        end
      end
    end
  end

  // Damage: first hit since the last tick is held until the tick; a hit
  // arriving in the tick cycle itself counts when nothing is pending.
  logic            dmg_vld;
  logic [HP_W-1:0] dmg_eff;
  always_comb begin
    dmg_vld    = pend_q | hit;
    dmg_eff    = pend_q ? pend_amt_q : dmg_amt;
    pend_d     = pend_q;
    pend_amt_d = pend_amt_q;
    hp_d       = hp_q;
    invuln_d   = invuln_q;
    if (frame_tick) begin
      pend_d   = 1'b0;
      invuln_d = (invuln_q != '0) ? (invuln_q - INV_W'(1)) : '0;
      if (!dead_q && dmg_vld && (invuln_q == '0)) begin
        hp_d     = (hp_q > dmg_eff) ? (hp_q - dmg_eff) : '0;
        invuln_d = INV_W'(INVULN_FRAMES);
      end
    end else if (hit && !pend_q) begin
      pend_d     = 1'b1;
      pend_amt_d = dmg_amt;
    end
    dead_d = dead_q | (hp_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x_q    <= coord_t'(X_START);
      pos_y_q    <= coord_t'(Y_FLOOR);
      flip_q     <= 1'b0;
      vst_q      <= GROUNDED;
      vy_q       <= '0;
      hp_q       <= HP_W'(HP_MAX);
      dead_q     <= 1'b0;
      invuln_q   <= '0;
      pend_q     <= 1'b0;
      pend_amt_q <= '0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      flip_q     <= flip_d;
      vst_q      <= vst_d;
      vy_q       <= vy_d;
      hp_q       <= hp_d;
      dead_q     <= dead_d;
      invuln_q   <= invuln_d;
      pend_q     <= pend_d;
      pend_amt_q <= pend_amt_d;
    end
  end

  // dead_d lets the killing tick itself drop the weapon.
  char_wpn_timer #(
    .WPN_FRAMES (WPN_FRAMES),
    .WPN_COOL   (WPN_COOL)
  ) u_wpn (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .mouse_left  (mouse_left),
    .dead        (dead_d),
    .draw_weapon (draw_weapon)
  );

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign flip_h  = flip_q;
  assign char_hp = hp_q;
  assign dead    = dead_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// tb_char_motion_ctrl: directed bench for char_motion_ctrl with default
// parameters. Expected values are queued when stimulus is driven and popped
// and compared after the DUT updates.
module tb_char_motion_ctrl;

  logic        clk, rst, frame_tick;
  logic        stepleft, stepright, stepjump, mouse_left, on_ground, hit;
  logic [3:0]  dmg_amt;
  logic [11:0] pos_x, pos_y;
  logic        flip_h, draw_weapon, dead;
  logic [3:0]  char_hp;

  char_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
    .mouse_left(mouse_left), .on_ground(on_ground),
    .hit(hit), .dmg_amt(dmg_amt),
    .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .draw_weapon(draw_weapon), .char_hp(char_hp), .dead(dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_X = 0, S_Y = 1, S_FLIP = 2, S_DRAW = 3, S_HP = 4, S_DEAD = 5;

  typedef struct {
    string  tag;
    int     sig;
    integer val;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  function automatic integer sample(input int sig);
    case (sig)
      S_X:    return integer'(pos_x);
      S_Y:    return integer'(pos_y);
      S_FLIP: return integer'(flip_h);
      S_DRAW: return integer'(draw_weapon);
      S_HP:   return integer'(char_hp);
      default: return integer'(dead);
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input integer val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t   e;
    integer obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = sample(e.sig);
      n_asrt++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_reset(input string tag);
    expect_v({tag, "_x"}, S_X, 100);
    expect_v({tag, "_y"}, S_Y, 400);
    expect_v({tag, "_flip"}, S_FLIP, 0);
    expect_v({tag, "_draw"}, S_DRAW, 0);
    expect_v({tag, "_hp"}, S_HP, 10);
    expect_v({tag, "_dead"}, S_DEAD, 0);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic tick_hit(input logic [3:0] amt);
    @(negedge clk); frame_tick = 1'b1; hit = 1'b1; dmg_amt = amt;
    @(negedge clk); frame_tick = 1'b0; hit = 1'b0; dmg_amt = '0;
  endtask

  task automatic pulse_hit(input logic [3:0] amt);
    @(negedge clk); hit = 1'b1; dmg_amt = amt;
    @(negedge clk); hit = 1'b0; dmg_amt = '0;
  endtask

  initial begin
    integer ex;
    rst = 1'b0; frame_tick = 1'b0; stepleft = 1'b0; stepright = 1'b0;
    stepjump = 1'b0; mouse_left = 1'b0; on_ground = 1'b1; hit = 1'b0;
    dmg_amt = '0;

    // Reset values
    repeat (3) @(negedge clk);
    expect_reset("rst");
    check_sb();
    rst = 1'b1;

    // Walk left into the X_MIN clamp
    stepleft = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      ex = (100 - 4 * i > 0) ? 100 - 4 * i : 0;
      expect_v("walk_left_x", S_X, ex);
      if (i == 1 || i == 30) expect_v("walk_left_flip", S_FLIP, 1);
      check_sb();
    end
    // Both buttons: no move, facing unchanged
    stepright = 1'b1;
    repeat (2) begin
      tick();
      expect_v("both_x", S_X, 0);
      expect_v("both_flip", S_FLIP, 1);
      check_sb();
    end
    // Walk right into the X_MAX clamp
    stepleft = 1'b0;
    for (int i = 1; i <= 245; i++) begin
      tick();
      if (i == 1 || i >= 239) begin
        ex = (4 * i < 960) ? 4 * i : 960;
        expect_v("walk_right_x", S_X, ex);
        if (i == 1) expect_v("walk_right_flip", S_FLIP, 0);
        check_sb();
      end
    end
    stepright = 1'b0;
    // Outputs hold between ticks
    repeat (5) @(negedge clk);
    expect_v("stable_x", S_X, 960);
    check_sb();

    // Jump from floor: rise 16 ticks, fall 16 ticks
    on_ground = 1'b0;
    stepjump  = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      stepjump = 1'b0;
      if (i <= 16) ex = 400 - (i * (33 - i)) / 2;
      else begin
        ex = 264 + ((i - 16) * (i - 15)) / 2;
        if (ex > 400) ex = 400;
      end
      expect_v("jump_y", S_Y, ex);
      check_sb();
    end
    expect_v("jump_x", S_X, 960);
    check_sb();

    // Weapon held: 15 on, 10 off, then on again
    on_ground  = 1'b1;
    mouse_left = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick();
      expect_v("wpn_draw", S_DRAW, (i <= 15) ? 1 : ((i <= 25) ? 0 : 1));
      check_sb();
    end

    // Reset mid-swing and mid-jump
    on_ground = 1'b0;
    stepjump  = 1'b1;
    tick();
    stepjump = 1'b0;
    expect_v("mid_y1", S_Y, 384);
    expect_v("mid_draw", S_DRAW, 1);
    check_sb();
    tick();
    expect_v("mid_y2", S_Y, 369);
    check_sb();
    @(negedge clk); rst = 1'b0;
    #2;
    expect_reset("midrst");
    check_sb();
    @(negedge clk); rst = 1'b1; mouse_left = 1'b0; on_ground = 1'b1;
    tick();
    expect_v("post_rst_y", S_Y, 400);
    expect_v("post_rst_draw", S_DRAW, 0);
    check_sb();

    // Damage and invulnerability window
    pulse_hit(4'd3);
    tick();
    expect_v("hit1_hp", S_HP, 7);
    expect_v("hit1_dead", S_DEAD, 0);
    check_sb();
    repeat (9) tick();
    pulse_hit(4'd5);
    tick();
    expect_v("hit_invuln_hp", S_HP, 7);
    check_sb();
    repeat (49) tick();
    pulse_hit(4'd2);
    tick();
    expect_v("hit_last_invuln_hp", S_HP, 7);
    check_sb();
    tick_hit(4'd3);
    expect_v("hit_coincident_hp", S_HP, 4);
    check_sb();
    repeat (60) tick();
    pulse_hit(4'd1);
    pulse_hit(4'd9);
    tick();
    expect_v("first_hit_wins_hp", S_HP, 3);
    check_sb();
    repeat (60) tick();
    mouse_left = 1'b1;
    tick();
    expect_v("pre_death_draw", S_DRAW, 1);
    check_sb();
    pulse_hit(4'd15);
    tick();
    expect_v("death_hp", S_HP, 0);
    expect_v("death_dead", S_DEAD, 1);
    expect_v("death_draw", S_DRAW, 0);
    check_sb();

    // Dead: everything frozen
    stepright = 1'b1; stepjump = 1'b1; on_ground = 1'b0;
    repeat (3) tick();
    pulse_hit(4'd1);
    tick();
    expect_v("frozen_x", S_X, 100);
    expect_v("frozen_y", S_Y, 400);
    expect_v("frozen_flip", S_FLIP, 0);
    expect_v("frozen_draw", S_DRAW, 0);
    expect_v("frozen_hp", S_HP, 0);
    expect_v("frozen_dead", S_DEAD, 1);
    check_sb();

    // Reset clears death
    stepright = 1'b0; stepjump = 1'b0; mouse_left = 1'b0; on_ground = 1'b1;
    @(negedge clk); rst = 1'b0;
    #2;
    expect_reset("revive");
    check_sb();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/char_motion_ctrl.md
# char_motion_ctrl

Parametrised per-frame character controller, the next generation of the movement and weapon logic behind the character draw path. It owns horizontal walking, a jump/gravity state machine, a timed weapon swing with cooldown, and hit points with an invulnerability window. It sits between the input/collision logic and the character/weapon draw stages. All state advances once per `frame_tick`; outputs are registered and feed `pos_x`/`pos_y`/`flip_h`/`draw_weapon` into the draw stages.

## Interface
- `X_MIN`, 0: left clamp for `pos_x`
- `X_MAX`, 960: right clamp for `pos_x`
- `X_START`, 100: reset `pos_x`
- `Y_FLOOR`, 400: floor clamp and reset `pos_y`
- `MOVE_STEP`, 4: px per tick horizontally
- `JUMP_V0`, 16: initial upward speed
- `GRAVITY`, 1: speed change per tick
- `VY_MAX`, 16: terminal fall speed
- `HP_W`, 4: hit-point width
- `HP_MAX`, 10: reset hit points
- `INVULN_FRAMES`, 60: post-hit immunity
- `WPN_FRAMES`, 15: swing length
- `WPN_COOL`, 10: cooldown after swing

Ports:
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `frame_tick` in 1: one-cycle pulse per frame
- `stepleft`, `stepright`, `stepjump`, `mouse_left`, `on_ground` in 1 each: levels, sampled at tick
- `hit` in 1: damage pulse, any cycle
- `dmg_amt` in HP_W: damage, valid with `hit`
- `pos_x`, `pos_y` out 12: character position
- `flip_h` out 1: 1 = facing left
- `draw_weapon` out 1: swing active
- `char_hp` out HP_W: hit points
- `dead` out 1: sticky, set when hp reaches 0

## Operation
- Reset values: `pos_x`=X_START, `pos_y`=Y_FLOOR, `flip_h`=0, `draw_weapon`=0, `char_hp`=HP_MAX, `dead`=0, vertical state GROUNDED, weapon state W_IDLE, vy=0, invuln=0, hit pending cleared.
- Horizontal movement:
  - `stepleft` only: `pos_x` -= MOVE_STEP, saturating at X_MIN; `flip_h`=1.
  - `stepright` only: `pos_x` += MOVE_STEP, saturating at X_MAX; `flip_h`=0.
  - Both or neither: no move; `flip_h` unchanged.
- Vertical FSM:
  - GROUNDED:
    - `stepjump` -> RISING with vy=JUMP_V0.
    - Otherwise, `!on_ground` and `pos_y`<Y_FLOOR -> FALLING with vy=0.
  - RISING: `pos_y` -= vy, saturating at 0; vy -= GRAVITY, saturating at 0.
    - Go to FALLING when the new vy is 0 or `pos_y` hits 0; vy becomes 0 in that case.
  - FALLING: vy=min(vy+GRAVITY, VY_MAX), then `pos_y` += vy.
    - If the result is ≥Y_FLOOR, `pos_y`=Y_FLOOR -> GROUNDED, vy=0.
    - `on_ground` at tick also -> GROUNDED, vy=0, position held.
- Weapon FSM:
  - W_IDLE, `mouse_left` -> W_SWING, counter=WPN_FRAMES.
  - W_SWING: `draw_weapon`=1; counter decrements per tick; at 0 -> W_COOL, counter=WPN_COOL.
  - W_COOL: counter decrements per tick; at 0 -> W_IDLE.
  - A held button re-triggers only from W_IDLE.
- Damage:
  - `hit` latches `dmg_amt` into a pending register. The first hit since the last tick wins; later hits before the tick are dropped.
  - At tick, if a hit is pending and invuln=0: `char_hp`=sat0(`char_hp`-dmg), invuln=INVULN_FRAMES. Pending is cleared either way.
  - invuln decrements per tick, saturating at 0.
  - `char_hp`=0 -> `dead`=1.
  - While `dead`: position, flip, weapon (forced W_IDLE, `draw_weapon`=0) and hp are frozen until reset.
- `hit` coincident with `frame_tick` is applied on that tick.

## Timing
- All outputs are registered and change exactly one `clk` after a `frame_tick` cycle; they are stable otherwise.
- Inputs other than `hit`/`dmg_amt` are sampled only in the `frame_tick` cycle.
- Two ticks in consecutive cycles are legal; each performs a full update.
- Asserting `rst` mid-jump or mid-swing returns everything to reset values immediately, with no tick needed.
- Arithmetic uses 13-bit intermediates for clamping; no wrap-around is permitted on any counter or position.

## Structure
- `char_pkg` holds:
  - `vstate_t` (GROUNDED, RISING, FALLING) and `wstate_t` (W_IDLE, W_SWING, W_COOL);
  - default parameter constants;
  - the 12-bit coordinate type.
- Sub-module `char_wpn_timer` contains the weapon FSM and counter. It takes `frame_tick`, `mouse_left` and `dead`, and outputs `draw_weapon`.

## Test plan
All scenarios use default parameters.
- Jump from floor: `stepjump` at tick 1 -> `pos_y` 384 after first tick, apex 264 after 16 ticks, back to 400 and GROUNDED after 32 ticks total.
- Walk: `stepleft` held 30 ticks from x=100 -> `pos_x` 0 after 25 ticks, holds 0, `flip_h`=1; both buttons held -> no movement.
- Weapon: `mouse_left` held -> `draw_weapon` high for exactly 15 ticks, low for 10, then high again.
- Damage: `hit` `dmg_amt`=3 -> hp 7; a second hit 10 ticks later is ignored; a hit at tick 61 -> hp 4; `dmg_amt`=15 -> hp 0, `dead`=1, inputs ignored.
- Edge: `hit` in the same cycle as `frame_tick` -> applied on that tick; `rst` low mid-swing/mid-jump -> all reset values next cycle.
